pixel_filter: RTL and testbench
===============================

# pixel_filter

Streaming point filter that sits directly downstream of the filter-selection screen: it consumes the 3-bit filter select and applies the chosen per-pixel colour transform to the 12-bit RGB (4:4:4) video stream. The select is latched once per frame, so a frame is never rendered with two filters. The output is a fixed-latency pipeline with coordinates delayed alongside pixels, ready for the display/compositing stage.

## Interface
- THRESHOLD, default 8: 4-bit luma threshold for the binary filter (pixel is white when Y >= THRESHOLD).
- clk_in  input  1  pixel clock, all logic on posedge.
- rst_in  input  1  synchronous, active-high reset.
- hcount_in  input  11  horizontal coordinate of pixel_in.
- vcount_in  input  10  vertical coordinate of pixel_in.
- pixel_in  input  12  {R[3:0],G[3:0],B[3:0]}.
- select_in  input  3  requested filter, from the selection screen.
- hcount_out  output  11  hcount_in delayed 3 cycles.
- vcount_out  output  10  vcount_in delayed 3 cycles.
- pixel_out  output  12  filtered pixel, aligned with hcount_out/vcount_out.
- active_select_out  output  3  filter currently applied at the input side.

## Operation
- Frame latch: when hcount_in==0 && vcount_in==0, active_select <= select_in. At all other times it holds. The pixel at (0,0) already uses the new value, because the stage-1 select is taken combinationally from select_in on that cycle.
- Each pipeline stage carries its own copy of the select. A latch change never alters pixels already in flight.
- Luma: Y = (5*R + 9*G + 2*B) >> 4.
  - The sum is 8 bits wide (max 240), so Y is 4 bits, range 0..15.
  - Truncate, no rounding.
- Filters, by select value:
  - 0: passthrough, out = pixel.
  - 1: grayscale, out = {Y,Y,Y}.
  - 2: invert, out = ~pixel.
  - 3: threshold, out = (Y >= THRESHOLD) ? 12'hFFF : 12'h000.
  - 4: posterize, each channel c becomes {c[3:2],c[3:2]}, giving levels 0/5/10/15.
  - 5: sepia.
    - R' = min(15, Y+3), computed 5 bits wide and saturated.
    - G' = Y.
    - B' = (Y>3) ? Y-3 : 0, floored at 0.
  - 6, 7: passthrough; these are not produced by the selection screen.
- Reset: all pipeline registers, hcount_out, vcount_out and pixel_out go to 0, and active_select_out goes to 0 (passthrough).
  - Reset mid-frame flushes the pipeline.
  - After reset, filter 0 is applied until the next (0,0) latch.

## Timing
- Latency is exactly 3 cycles, input to pixel_out/hcount_out/vcount_out.
- Stage 1: register pixel, coordinates and effective select; compute the weighted sum.
- Stage 2: register Y and compute all filter results.
- Stage 3: mux by the carried select and register the outputs.
- Throughput is one pixel per cycle, with no stalls and no handshake; the stream is assumed continuous.
- active_select_out updates on the clock edge after (0,0) is presented.
- Blanking pixels are filtered like any other; blanking masking is the consumer's responsibility.
- For the first 3 cycles after reset deasserts, outputs are 0.

## Test plan
- Reset and passthrough: assert rst_in for 2 cycles, then stream pixel 12'hF84.
  - Outputs are 0 during reset and for 3 cycles after.
  - pixel_out = 12'hF84 follows.
  - active_select_out = 0.
- Latch per frame, input 12'hF84 (Y=9): set select_in=1 mid-frame.
  - Output stays 12'hF84 until the pixel presented at (0,0).
  - From that pixel on, pixel_out = 12'h999, appearing 3 cycles later.
  - active_select_out = 1.
- All filters on 12'hF84 (one frame each), expected outputs:
  - invert: 12'h07B.
  - threshold (THRESHOLD=8): 12'hFFF.
  - posterize: 12'hFA5.
  - sepia: 12'hC96.
  - select 6 and 7: 12'hF84.
- Sepia saturation: select=5.
  - 12'hFFF (Y=15) gives 12'hFFC (R clamped to 15).
  - 12'h000 gives 12'h300 (B floored at 0).
- Threshold boundary with THRESHOLD=8:
  - 12'h888 (Y=8) gives 12'hFFF.
  - 12'h777 (Y=7) gives 12'h000.
- In-flight and reset: toggle select_in at (0,0) while differing pixels stream.
  - The 2 pixels before (0,0) keep the old filter.
  - The (0,0) pixel onward uses the new filter.
  - Hcount/vcount stay aligned 3 cycles behind.
  - Asserting rst_in mid-frame zeroes the outputs on the next edge, and active_select_out returns to 0.

Source files
------------

// File: rtl/pixel_filter.sv
// Three-stage streaming point filter on 12-bit RGB 4:4:4 pixels.
// The filter select is latched once per frame at (0,0) and travels with each pixel.
module pixel_filter #(
    parameter logic [3:0] THRESHOLD = 4'd8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [11:0] pixel_in,
    input  logic [2:0]  select_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [11:0] pixel_out,
    output logic [2:0]  active_select_out
);

    logic [2:0]  active_select_q;
    logic [2:0]  eff_select;
    logic        frame_start;
    logic [7:0]  sum_d;

    logic [11:0] pix1_q;
    logic [10:0] h1_q;
    logic [9:0]  v1_q;
    logic [2:0]  sel1_q;
    logic [7:0]  sum1_q;

    logic [11:0] pix2_q;
    logic [10:0] h2_q;
    logic [9:0]  v2_q;
    logic [2:0]  sel2_q;
    logic [3:0]  y2_q;

    logic [11:0] pix3_q;
    logic [10:0] h3_q;
    logic [9:0]  v3_q;

    logic [11:0] gray, inverted, thresh, poster, sepia, filt_d;
    logic [4:0]  sep_r_wide;
    logic [3:0]  sep_r, sep_b;

    // The (0,0) pixel must already see the newly requested filter.
    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign eff_select  = frame_start ? select_in : active_select_q;

    // Max 5*15 + 9*15 + 2*15 = 240, so 8 bits suffice.
    assign sum_d = ({4'b0, pixel_in[11:8]} * 8'd5) +
                   ({4'b0, pixel_in[7:4]}  * 8'd9) +
                   ({4'b0, pixel_in[3:0]}  * 8'd2);

    always_comb begin
        gray       = {y2_q, y2_q, y2_q};
        inverted   = ~pix2_q;
        thresh     = (y2_q >= THRESHOLD) ? 12'hFFF : 12'h000;
        poster     = {pix2_q[11:10], pix2_q[11:10],
                      pix2_q[7:6],   pix2_q[7:6],
                      pix2_q[3:2],   pix2_q[3:2]};
        sep_r_wide = {1'b0, y2_q} + 5'd3;
        sep_r      = sep_r_wide[4] ? 4'hF : sep_r_wide[3:0];
        sep_b      = (y2_q > 4'd3) ? (y2_q - 4'd3) : 4'd0;
        sepia      = {sep_r, y2_q, sep_b};

        filt_d = pix2_q;
        case (sel2_q)
            3'd1:    filt_d = gray;
            3'd2:    filt_d = inverted;
            3'd3:    filt_d = thresh;
            3'd4:    filt_d = poster;
            3'd5:    filt_d = sepia;
            default: filt_d = pix2_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active_select_q <= 3'd0;
            pix1_q <= '0;
            h1_q   <= '0;
            v1_q   <= '0;
            sel1_q <= '0;
            sum1_q <= '0;
            pix2_q <= '0;
            h2_q   <= '0;
            v2_q   <= '0;
            sel2_q <= '0;
            y2_q   <= '0;
            pix3_q <= '0;
            h3_q   <= '0;
            v3_q   <= '0;
        end else begin
            if (frame_start) begin
                active_select_q <= select_in;
            end
            pix1_q <= pixel_in;
            h1_q   <= hcount_in;
            v1_q   <= vcount_in;
            sel1_q <= eff_select;
            sum1_q <= sum_d;

            pix2_q <= pix1_q;
            h2_q   <= h1_q;
            v2_q   <= v1_q;
            sel2_q <= sel1_q;
            y2_q   <= sum1_q[7:4];

            pix3_q <= filt_d;
            h3_q   <= h2_q;
            v3_q   <= v2_q;
        end
    end

    assign pixel_out         = pix3_q;
    assign hcount_out        = h3_q;
    assign vcount_out        = v3_q;
    assign active_select_out = active_select_q;

endmodule

// File: tb/tb_pixel_filter.sv
// Scoreboard bench for pixel_filter: the driver queues hand-computed expectations,
// and the monitor pops and compares them at the cycle each one is due.
module tb_pixel_filter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [11:0] pixel_in;
    logic [2:0]  select_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [11:0] pixel_out;
    logic [2:0]  active_select_out;

    pixel_filter #(.THRESHOLD(4'd8)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .pixel_in          (pixel_in),
        .select_in         (select_in),
        .hcount_out        (hcount_out),
        .vcount_out        (vcount_out),
        .pixel_out         (pixel_out),
        .active_select_out (active_select_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          due;
        logic [11:0] pix;
        logic [10:0] h;
        logic [9:0]  v;
    } pix_item_t;

    typedef struct {
        int         due;
        logic [2:0] sel;
    } sel_item_t;

    pix_item_t pq[$];
    sel_item_t sq[$];
    int        cycle = 0;
    int        tests = 0;
    int        fails = 0;
    logic [2:0] msel = 3'd0;

    // Outputs from a pixel driven before edge c+1 are due after edge c+3.
    task automatic drive(input logic [11:0] pix, input logic [10:0] h, input logic [9:0] v,
                         input logic [2:0] sel, input logic [11:0] exp_pix);
        @(negedge clk_in);
        rst_in    = 1'b0;
        pixel_in  = pix;
        hcount_in = h;
        vcount_in = v;
        select_in = sel;
        pq.push_back('{cycle + 3, exp_pix, h, v});
        if (h == 11'd0 && v == 10'd0) msel = sel;
        sq.push_back('{cycle + 1, msel});
    endtask

    // Reset flushes everything in flight; the next three outputs are zero.
    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk_in);
            rst_in    = 1'b1;
            pixel_in  = 12'hABC;
            hcount_in = 11'd7;
            vcount_in = 10'd7;
            select_in = 3'd5;
            while (pq.size() > 0 && pq[$].due > cycle) void'(pq.pop_back());
            for (int k = 1; k <= 3; k++) pq.push_back('{cycle + k, 12'h000, 11'd0, 10'd0});
            msel = 3'd0;
            sq.push_back('{cycle + 1, 3'd0});
        end
    endtask

    initial begin : monitor
        pix_item_t pi;
        sel_item_t si;
        forever begin
            @(posedge clk_in);
            cycle++;
            #1;
            while (pq.size() > 0 && pq[0].due <= cycle) begin
                pi = pq.pop_front();
                tests++;
                if (pi.due != cycle || pixel_out !== pi.pix || hcount_out !== pi.h ||
                    vcount_out !== pi.v) begin
                    fails++;
                    $display("FAIL pixel@%0d: got pix=%h h=%0d v=%0d, want pix=%h h=%0d v=%0d (due %0d)",
                             cycle, pixel_out, hcount_out, vcount_out, pi.pix, pi.h, pi.v, pi.due);
                end
            end
            while (sq.size() > 0 && sq[0].due <= cycle) begin
                si = sq.pop_front();
                tests++;
                if (si.due != cycle || active_select_out !== si.sel) begin
                    fails++;
                    $display("FAIL active_select@%0d: got %0d, want %0d (due %0d)",
                             cycle, active_select_out, si.sel, si.due);
                end
            end
        end
    end

    logic [2:0]  fsel [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [11:0] fexp [6] = '{12'h07B, 12'hFFF, 12'hFA5, 12'hC96, 12'hF84, 12'hF84};

    initial begin
        rst_in    = 1'b1;
        pixel_in  = '0;
        hcount_in = '0;
        vcount_in = '0;
        select_in = '0;

        do_reset(2);
        for (int i = 0; i < 4; i++) drive(12'hF84, 11'(10 + i), 10'd5, 3'd0, 12'hF84);

        // Mid-frame request is ignored until (0,0); F84 has Y=9.
        drive(12'hF84, 11'd14, 10'd5, 3'd1, 12'hF84);
        drive(12'hF84, 11'd15, 10'd5, 3'd1, 12'hF84);
        drive(12'hF84, 11'd0,  10'd0, 3'd1, 12'h999);
        drive(12'hF84, 11'd1,  10'd0, 3'd1, 12'h999);

        for (int i = 0; i < 6; i++) begin
            drive(12'hF84, 11'd0, 10'd0, fsel[i], fexp[i]);
            drive(12'hF84, 11'd1, 10'd0, fsel[i], fexp[i]);
        end

        drive(12'hFFF, 11'd0, 10'd0, 3'd5, 12'hFFC);
        drive(12'h000, 11'd1, 10'd0, 3'd5, 12'h300);

        drive(12'h888, 11'd0, 10'd0, 3'd3, 12'hFFF);
        drive(12'h777, 11'd1, 10'd0, 3'd3, 12'h000);

        // Select toggles to grayscale at (0,0); preceding pixels stay on threshold.
        drive(12'h888, 11'd1198, 10'd524, 3'd1, 12'hFFF);
        drive(12'h777, 11'd1199, 10'd524, 3'd1, 12'h000);
        drive(12'hF84, 11'd0,    10'd0,   3'd1, 12'h999);
        drive(12'h123, 11'd1,    10'd0,   3'd1, 12'h111);
        drive(12'h888, 11'd2,    10'd0,   3'd1, 12'h888);

        do_reset(1);
        drive(12'hF84, 11'd3, 10'd0, 3'd1, 12'hF84);
        drive(12'hFFF, 11'd4, 10'd0, 3'd1, 12'hFFF);

        repeat (6) @(negedge clk_in);
        if (pq.size() != 0 || sq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pixel and %0d select items pending, want 0 and 0",
                     pq.size(), sq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
